rf_wb_ctrl: RTL and testbench

- Write-side initiator for the core's 32x32 register file.
- Merges ALU and LSU results into one writeback queue and drives the regfile write port (wen/rdidx/wdat), one write per cycle.
- Keeps a busy-bit scoreboard of registers with in-flight writes, and stalls issue on RAW and WAW hazards.
- Sits between the execute/LSU stages and the register file.

---
 rtl/rf_wb_ctrl.sv | 148 ++++++++++++++
 tb/tb_rf_wb_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: merges ALU/LSU results into a writeback FIFO, drives the regfile
// write port and tracks in-flight destinations. Optional macro RF_WB_BYPASS_EN.
module rf_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_iss_valid,
  input  logic            i_iss_rd_en,
  input  logic [4:0]      i_iss_rd_idx,
  input  logic [4:0]      i_iss_rs1_idx,
  input  logic [4:0]      i_iss_rs2_idx,
  output logic            o_iss_stall,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rdidx,
  input  logic [XLEN-1:0] i_alu_wdat,
  output logic            o_alu_ready,
  input  logic            i_lsu_valid,
  input  logic [4:0]      i_lsu_rdidx,
  input  logic [XLEN-1:0] i_lsu_wdat,
  output logic            o_lsu_ready,
  output logic            o_rf_wen,
  output logic [4:0]      o_rf_rdidx,
  output logic [XLEN-1:0] o_rf_wdat,
  output logic [31:0]     o_sb_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]      rdidx;
    logic [XLEN-1:0] wdat;
  } ent_t;

  typedef enum logic {SRC_ALU, SRC_LSU} src_t;

  ent_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  src_t          rr, rr_nxt;
  logic [31:0]   busy, busy_nxt;

  logic full, empty;
  logic alu_win, lsu_win;
  logic push_alu, push_lsu, push, pop, byp, fifo_push;
  logic iss_set;
  ent_t push_ent, head;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A source only loses when the other one is valid and has priority;
  // with nothing valid both report ready.
  assign alu_win = ~(i_lsu_valid & (~i_alu_valid | (rr == SRC_LSU)));
  assign lsu_win = ~(i_alu_valid & (~i_lsu_valid | (rr == SRC_ALU)));

  assign o_alu_ready = alu_win & ~full;
  assign o_lsu_ready = lsu_win & ~full;
  assign push_alu    = i_alu_valid & o_alu_ready;
  assign push_lsu    = i_lsu_valid & o_lsu_ready;
  assign push        = push_alu | push_lsu;
  assign push_ent    = push_alu ? ent_t'{i_alu_rdidx, i_alu_wdat}
                                : ent_t'{i_lsu_rdidx, i_lsu_wdat};
  assign pop         = ~empty;

`ifdef RF_WB_BYPASS_EN
  // Only with nothing queued, so the output register never sees two loads.
  assign byp = push & empty;
`else
  assign byp = 1'b0;
`endif

  assign fifo_push = push & ~byp;

  assign o_iss_stall = i_iss_valid & (busy[i_iss_rs1_idx] | busy[i_iss_rs2_idx] |
                                      (i_iss_rd_en & busy[i_iss_rd_idx]));
  assign iss_set     = i_iss_valid & ~o_iss_stall & i_iss_rd_en & (i_iss_rd_idx != 5'd0);
  assign o_sb_busy   = busy;

  always_comb begin
    count_nxt = count;
    case ({fifo_push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    rr_nxt = rr;
    if (push & i_alu_valid & i_lsu_valid)
      rr_nxt = (rr == SRC_ALU) ? SRC_LSU : SRC_ALU;
  end

  // Set after clear so a same-edge set of the retiring index wins.
  always_comb begin
    busy_nxt = busy;
    if (o_rf_wen)
      busy_nxt[o_rf_rdidx] = 1'b0;
    if (iss_set)
      busy_nxt[i_iss_rd_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr     <= SRC_ALU;
      busy   <= '0;
    end else begin
      if (fifo_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      rr    <= rr_nxt;
      busy  <= busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push)
      mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rf_wen   <= 1'b0;
      o_rf_rdidx <= '0;
      o_rf_wdat  <= '0;
    end else if (byp) begin
      o_rf_wen   <= (push_ent.rdidx != 5'd0);
      o_rf_rdidx <= push_ent.rdidx;
      o_rf_wdat  <= push_ent.wdat;
    end else if (pop) begin
      o_rf_wen   <= (head.rdidx != 5'd0);
      o_rf_rdidx <= head.rdidx;
      o_rf_wdat  <= head.wdat;
    end else begin
      o_rf_wen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Randomised bench for rf_wb_ctrl against a queue-based reference model.
module tb_rf_wb_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_v, iss_rd_en;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_stall;
  logic        alu_v, lsu_v, alu_rdy, lsu_rdy;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_d, lsu_d;
  logic        rf_wen;
  logic [4:0]  rf_rdidx;
  logic [31:0] rf_wdat;
  logic [31:0] sb_busy;

  int n_chk = 0;
  int n_err = 0;

  wb_t         m_q[$];
  bit          m_lsu_prio;
  bit          m_busy [32];
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  always #5 clk = ~clk;

  rf_wb_ctrl #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .i_iss_valid(iss_v), .i_iss_rd_en(iss_rd_en), .i_iss_rd_idx(iss_rd),
    .i_iss_rs1_idx(iss_rs1), .i_iss_rs2_idx(iss_rs2), .o_iss_stall(iss_stall),
    .i_alu_valid(alu_v), .i_alu_rdidx(alu_rd), .i_alu_wdat(alu_d), .o_alu_ready(alu_rdy),
    .i_lsu_valid(lsu_v), .i_lsu_rdidx(lsu_rd), .i_lsu_wdat(lsu_d), .o_lsu_ready(lsu_rdy),
    .o_rf_wen(rf_wen), .o_rf_rdidx(rf_rdidx), .o_rf_wdat(rf_wdat), .o_sb_busy(sb_busy)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // One clock: check combinational outputs, step the model, check registers.
  task automatic cycle();
    bit  full, e_ar, e_lr, e_st, acc_a, acc_l, both, old_wen;
    logic [4:0] old_rd;
    wb_t e;
    #1;
    full = (m_q.size() >= DEPTH);
    if (alu_v && lsu_v) begin
      e_ar = !full && !m_lsu_prio;
      e_lr = !full &&  m_lsu_prio;
    end else if (alu_v) begin
      e_ar = !full; e_lr = 1'b0;
    end else if (lsu_v) begin
      e_ar = 1'b0;  e_lr = !full;
    end else begin
      e_ar = !full; e_lr = !full;
    end
    e_st = iss_v && ((iss_rs1 != 0 && m_busy[iss_rs1]) || (iss_rs2 != 0 && m_busy[iss_rs2]) ||
                     (iss_rd_en && iss_rd != 0 && m_busy[iss_rd]));
    chk("alu_ready", alu_rdy, e_ar);
    chk("lsu_ready", lsu_rdy, e_lr);
    chk("iss_stall", iss_stall, e_st);
    acc_a = alu_v && e_ar;
    acc_l = lsu_v && e_lr;
    both  = alu_v && lsu_v;
    @(posedge clk);
    #1;
    if (rst) begin
      m_q.delete();
      m_lsu_prio = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
      m_wen = 0; m_rd = 0; m_wd = 0;
    end else begin
      old_wen = m_wen;
      old_rd  = m_rd;
      e.rd = acc_a ? alu_rd : lsu_rd;
      e.d  = acc_a ? alu_d  : lsu_d;
`ifdef RF_WB_BYPASS_EN
      if ((acc_a || acc_l) && m_q.size() == 0) begin
        m_wen = (e.rd != 0); m_rd = e.rd; m_wd = e.d;
      end else
`endif
      begin
        if (m_q.size() > 0) begin
          wb_t h = m_q.pop_front();
          m_wen = (h.rd != 0); m_rd = h.rd; m_wd = h.d;
        end else begin
          m_wen = 0;
        end
        if (acc_a || acc_l) m_q.push_back(e);
      end
      if (both && (acc_a || acc_l)) m_lsu_prio = !m_lsu_prio;
      if (old_wen) m_busy[old_rd] = 0;
      if (iss_v && !e_st && iss_rd_en && iss_rd != 0) m_busy[iss_rd] = 1;
    end
    chk("rf_wen", rf_wen, m_wen);
    chk("rf_rdidx", rf_rdidx, m_rd);
    chk("rf_wdat", rf_wdat, m_wd);
    chk("sb_busy", sb_busy, busy_vec());
    if (acc_a) alu_v = 1'b0;
    if (acc_l) lsu_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_iss();
    iss_v = 0; iss_rd_en = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
  endtask

  initial begin
    rst = 1; alu_v = 0; lsu_v = 0; alu_rd = 0; lsu_rd = 0; alu_d = 0; lsu_d = 0;
    idle_iss();
    m_lsu_prio = 0; m_wen = 0; m_rd = 0; m_wd = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
    @(negedge clk);
    cycle(); cycle();
    rst = 0;
    chk("reset_wen", rf_wen, 1'b0);
    chk("reset_busy", sb_busy, 32'h0);
    cycle(); cycle();

    // RAW hazard on x5, cleared by an ALU writeback
    iss_v = 1; iss_rd_en = 1; iss_rd = 5;
    cycle();
    iss_rd_en = 0; iss_rd = 0; iss_rs1 = 5;
    #1 chk("raw_stall", iss_stall, 1'b1);
    cycle();
    alu_v = 1; alu_rd = 5; alu_d = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) cycle();
    chk("raw_released", iss_stall, 1'b0);
    idle_iss();
    cycle();

    // Both sources contending: rd 1..4 from ALU, 11..14 from LSU
    for (int i = 0, a = 0, l = 0; i < 14; i++) begin
      if (!alu_v && a < 4) begin alu_v = 1; alu_rd = 5'(1 + a);  alu_d = 32'hA000 + a; a++; end
      if (!lsu_v && l < 4) begin lsu_v = 1; lsu_rd = 5'(11 + l); lsu_d = 32'hB000 + l; l++; end
      cycle();
    end

    // x0 result and x0 issue
    alu_v = 1; alu_rd = 0; alu_d = 32'h1234;
    iss_v = 1; iss_rd_en = 1; iss_rd = 0; iss_rs1 = 0;
    cycle();
    idle_iss();
    for (int i = 0; i < 3; i++) cycle();
    chk("x0_busy", sb_busy, 32'h0);

    // Reset mid-traffic with busy[7] set
    iss_v = 1; iss_rd_en = 1; iss_rd = 7;
    alu_v = 1; alu_rd = 9; alu_d = 32'h99; lsu_v = 1; lsu_rd = 10; lsu_d = 32'hAA;
    cycle();
    idle_iss();
    rst = 1;
    cycle();
    rst = 0;
    chk("midrst_wen", rf_wen, 1'b0);
    chk("midrst_busy", sb_busy, 32'h0);
    alu_v = 0; lsu_v = 0;
    cycle();

    // Random traffic; sources hold until accepted
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!alu_v && $urandom_range(0, 1)) begin
        alu_v = 1; alu_rd = 5'($urandom_range(0, 7)); alu_d = $urandom;
      end
      if (!lsu_v && $urandom_range(0, 1)) begin
        lsu_v = 1; lsu_rd = 5'($urandom_range(0, 7)); lsu_d = $urandom;
      end
      iss_v     = 1'($urandom_range(0, 1));
      iss_rd_en = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
